// File: rtl/frame_ram_arbiter_if.sv
// Client access port onto the frame RAM: held request plus single-cycle grant,
// read data returns on rvalid one cycle after a read grant.
interface frame_ram_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 3
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Sole owner of the frame RAM port: video > clear sweep > round-robin(C0,C1), grant is combinational,
// read data returns 1 cycle after the grant; losers simply keep req high until gnt.
module frame_ram_arbiter #(
  parameter int DEPTH    = 4800,
  parameter int AW       = 13,
  parameter int DW       = 3,
  parameter int OOR_DATA = 4
) (
  input  logic                    px_clk,
  input  logic                    rstn,
  input  logic                    vid_req,
  input  logic [AW-1:0]           vid_addr,
  output logic                    vid_rvalid,
  output logic [DW-1:0]           vid_rdata,
  frame_ram_arbiter_if.slave      c0,
  frame_ram_arbiter_if.slave      c1,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    clear_done,
  output logic [AW-1:0]           ram_addr,
  output logic                    ram_we,
  output logic [DW-1:0]           ram_wdata,
  input  logic [DW-1:0]           ram_rdata
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam logic [DW-1:0] OOR_D   = DW'(OOR_DATA);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  state_t        state, stateNxt;
  logic [AW-1:0] clrCnt, clrCntNxt;
  logic          rrLast, rrLastNxt;       // 0 = C0 granted last, 1 = C1
  logic          clearDone, clearDoneNxt;
  logic          vidRd, vidRdNxt;
  logic          c0Rd, c0RdNxt;
  logic          c1Rd, c1RdNxt;
  logic          oorRd;

  logic [AW-1:0] accAddr;
  logic          accWe;
  logic [DW-1:0] accWdata;
  logic          accOor;
  logic          c0Gnt, c1Gnt;
  logic [DW-1:0] rdRet;

  always_ff @(posedge px_clk) begin
    if (!rstn) begin
      state     <= IDLE;
      clrCnt    <= '0;
      rrLast    <= 1'b1;
      clearDone <= 1'b0;
      vidRd     <= 1'b0;
      c0Rd      <= 1'b0;
      c1Rd      <= 1'b0;
      oorRd     <= 1'b0;
    end else begin
      state     <= stateNxt;
      clrCnt    <= clrCntNxt;
      rrLast    <= rrLastNxt;
      clearDone <= clearDoneNxt;
      vidRd     <= vidRdNxt;
      c0Rd      <= c0RdNxt;
      c1Rd      <= c1RdNxt;
      oorRd     <= accOor;
    end
  end

  always_comb begin
    stateNxt     = state;
    clrCntNxt    = clrCnt;
    rrLastNxt    = rrLast;
    clearDoneNxt = 1'b0;
    accAddr      = '0;
    accWe        = 1'b0;
    accWdata     = '0;
    c0Gnt        = 1'b0;
    c1Gnt        = 1'b0;
    vidRdNxt     = 1'b0;
    c0RdNxt      = 1'b0;
    c1RdNxt      = 1'b0;

    if (vid_req) begin
      accAddr  = vid_addr;
      vidRdNxt = 1'b1;
    end else if (state == CLEAR) begin
      accAddr   = clrCnt;
      accWe     = 1'b1;
      clrCntNxt = clrCnt + AW'(1);
      if (clrCnt == LAST_A) begin
        stateNxt     = IDLE;
        clearDoneNxt = 1'b1;
      end
    end else if (c0.req && (!c1.req || rrLast)) begin
      c0Gnt     = 1'b1;
      accAddr   = c0.addr;
      accWe     = c0.we;
      accWdata  = c0.wdata;
      c0RdNxt   = !c0.we;
      rrLastNxt = 1'b0;
    end else if (c1.req) begin
      c1Gnt     = 1'b1;
      accAddr   = c1.addr;
      accWe     = c1.we;
      accWdata  = c1.wdata;
      c1RdNxt   = !c1.we;
      rrLastNxt = 1'b1;
    end

    // A start pulse while already sweeping is ignored rather than restarting.
    if (state == IDLE && clear_start) begin
      stateNxt  = CLEAR;
      clrCntNxt = '0;
    end
  end

  assign accOor = (accAddr >= DEPTH_A);

  // Combinational outputs are held at zero while reset is asserted.
  assign ram_addr  = rstn ? accAddr : '0;
  assign ram_we    = rstn & accWe & ~accOor;
  assign ram_wdata = rstn ? accWdata : '0;
  assign c0.gnt    = rstn & c0Gnt;
  assign c1.gnt    = rstn & c1Gnt;

  assign rdRet      = oorRd ? OOR_D : ram_rdata;
  assign vid_rvalid = vidRd;
  assign vid_rdata  = vidRd ? rdRet : '0;
  assign c0.rvalid  = c0Rd;
  assign c0.rdata   = c0Rd ? rdRet : '0;
  assign c1.rvalid  = c1Rd;
  assign c1.rdata   = c1Rd ? rdRet : '0;

  assign clear_busy = (state == CLEAR);
  assign clear_done = clearDone;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter: reads are scored through per-port expectation queues.
module tb_frame_ram_arbiter;
  localparam int DEPTH = 4800;
  localparam int AW = 13;
  localparam int DW = 3;
  localparam logic [AW-1:0] DEPTH_A = 13'd4800;

  logic          px_clk = 1'b0;
  logic          rstn;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          clear_start, clear_busy, clear_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  frame_ram_arbiter_if #(.AW(AW), .DW(DW)) c0If ();
  frame_ram_arbiter_if #(.AW(AW), .DW(DW)) c1If ();

  frame_ram_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .OOR_DATA(4)) dut (
    .px_clk(px_clk), .rstn(rstn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .c0(c0If.slave), .c1(c1If.slave),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 px_clk = ~px_clk;

  // Frame RAM model, pre-filled with 7 so a wipe is visible.
  logic [DW-1:0] mem [DEPTH] = '{default: 3'd7};
  always @(posedge px_clk) begin
    if (ram_we && ram_addr < DEPTH_A) mem[ram_addr] <= ram_wdata;
    ram_rdata <= (ram_addr < DEPTH_A) ? mem[ram_addr] : 3'd0;
  end

  int cyc = 0;
  always @(posedge px_clk) cyc <= cyc + 1;

  typedef struct { int data; int cyc; } exp_t;
  exp_t vidQ[$], c0Q[$], c1Q[$];

  int compared = 0, mismatched = 0;
  int busyCycles = 0, clearWrites = 0, clearGrants = 0, doneCount = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pushExp(input int id, input int data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + 1;
    case (id)
      0: c0Q.push_back(e);
      1: c1Q.push_back(e);
      default: vidQ.push_back(e);
    endcase
  endtask

  task automatic popCheck(input int id, input int act, input string name);
    exp_t e;
    int n;
    n = (id == 0) ? c0Q.size() : (id == 1) ? c1Q.size() : vidQ.size();
    if (n == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s unexpected rvalid: got data %0d, expected no rvalid", name, act);
    end else begin
      case (id)
        0: e = c0Q.pop_front();
        1: e = c1Q.pop_front();
        default: e = vidQ.pop_front();
      endcase
      chk({name, " data"}, act, e.data);
      chk({name, " cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge px_clk) begin
    if (vid_rvalid) popCheck(2, int'(vid_rdata), "vid_rd");
    if (c0If.rvalid) popCheck(0, int'(c0If.rdata), "c0_rd");
    if (c1If.rvalid) popCheck(1, int'(c1If.rdata), "c1_rd");
    if (clear_busy) begin
      busyCycles++;
      if (ram_we && ram_wdata == 3'd0) clearWrites++;
      if (c0If.gnt || c1If.gnt) clearGrants++;
    end
    if (clear_done) doneCount++;
  end

  task automatic setClient(input int id, input logic req, input logic we, input int addr, input int wdata);
    if (id == 0) begin
      c0If.req = req; c0If.we = we; c0If.addr = AW'(addr); c0If.wdata = DW'(wdata);
    end else begin
      c1If.req = req; c1If.we = we; c1If.addr = AW'(addr); c1If.wdata = DW'(wdata);
    end
  endtask

  function automatic logic gntOf(input int id);
    return (id == 0) ? c0If.gnt : c1If.gnt;
  endfunction

  // Issue one access, wait (bounded) for gnt; push expected read data at the grant.
  task automatic clientAccess(input int id, input logic we, input int addr, input int wdata,
                              input int expData, output int waited);
    bit got = 0;
    waited = 0;
    @(posedge px_clk); #1;
    setClient(id, 1'b1, we, addr, wdata);
    for (int w = 0; w < 8 && !got; w++) begin
      @(negedge px_clk);
      if (gntOf(id)) begin
        got = 1;
        if (!we) pushExp(id, expData);
      end else begin
        waited++;
        @(posedge px_clk); #1;
      end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL c%0d gnt timeout: got no gnt in 8 cycles, expected gnt", id);
    end
    @(posedge px_clk); #1;
    setClient(id, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, doneSnap, nonZero;
    bit doneSeen, got;
    rstn = 1'b0; vid_req = 1'b0; vid_addr = '0; clear_start = 1'b0;
    setClient(0, 1'b0, 1'b0, 0, 0);
    setClient(1, 1'b0, 1'b0, 0, 0);

    // Reset state
    repeat (3) @(posedge px_clk);
    @(negedge px_clk);
    chk("rst ram_we", ram_we, 0);
    chk("rst c0_gnt", c0If.gnt, 0);
    chk("rst vid_rvalid", vid_rvalid, 0);
    chk("rst clear_busy", clear_busy, 0);
    chk("rst clear_done", clear_done, 0);
    @(posedge px_clk); #1 rstn = 1'b1;

    // C0 write then read at tile (25,40)
    clientAccess(0, 1'b1, 25*80+40, 6, 0, w);
    chk("t1 wr gnt latency", w, 0);
    clientAccess(0, 1'b0, 25*80+40, 0, 6, w);
    chk("t1 rd gnt latency", w, 0);

    // Video and C0 together: video first, C0 next cycle
    @(posedge px_clk); #1;
    vid_req = 1'b1; vid_addr = AW'(2040);
    pushExp(2, 6);
    setClient(0, 1'b1, 1'b1, 10, 3);
    @(negedge px_clk);
    chk("t2 c0_gnt under video", c0If.gnt, 0);
    chk("t2 ram_addr video", int'(ram_addr), 2040);
    chk("t2 ram_we video", ram_we, 0);
    @(posedge px_clk); #1 vid_req = 1'b0;
    @(negedge px_clk);
    chk("t2 c0_gnt after video", c0If.gnt, 1);
    chk("t2 ram_we c0", ram_we, 1);
    @(posedge px_clk); #1 setClient(0, 1'b0, 1'b0, 0, 0);
    clientAccess(1, 1'b0, 10, 0, 3, w);

    // Both clients held for 4 cycles: C0,C1,C0,C1
    @(posedge px_clk); #1;
    setClient(0, 1'b1, 1'b0, 2040, 0);
    setClient(1, 1'b1, 1'b0, 10, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge px_clk);
      chk("t3 c0_gnt", c0If.gnt, (i % 2 == 0) ? 1 : 0);
      chk("t3 c1_gnt", c1If.gnt, (i % 2 == 0) ? 0 : 1);
      if (c0If.gnt) pushExp(0, 6);
      if (c1If.gnt) pushExp(1, 3);
      @(posedge px_clk); #1;
    end
    setClient(0, 1'b0, 1'b0, 0, 0);
    setClient(1, 1'b0, 1'b0, 0, 0);

    // Out-of-range write is granted but dropped; read returns the wall sprite
    @(posedge px_clk); #1 setClient(1, 1'b1, 1'b1, 4800, 5);
    @(negedge px_clk);
    chk("t5 oor c1_gnt", c1If.gnt, 1);
    chk("t5 oor ram_we", ram_we, 0);
    @(posedge px_clk); #1 setClient(1, 1'b0, 1'b0, 0, 0);
    clientAccess(1, 1'b0, 4800, 0, 4, w);

    // Board wipe with video every 2nd cycle and C0 held throughout
    @(posedge px_clk); #1 clear_start = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 12000 && !doneSeen; i++) begin
      @(posedge px_clk); #1;
      clear_start = 1'b0;
      if (i == 0) setClient(0, 1'b1, 1'b0, 2040, 0);
      vid_req = (i % 2 == 0);
      vid_addr = AW'(5000);
      if (vid_req) pushExp(2, 4);
      @(negedge px_clk);
      if (clear_done) doneSeen = 1;
    end
    chk("t4 clear_done seen", doneSeen, 1);
    chk("t4 busy cycles", busyCycles, 9600);
    chk("t4 zero writes", clearWrites, 4800);
    chk("t4 client grants in clear", clearGrants, 0);
    @(posedge px_clk); #1 vid_req = 1'b0;
    got = 0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge px_clk);
      if (c0If.gnt) begin got = 1; pushExp(0, 0); end
      else begin @(posedge px_clk); #1; end
    end
    chk("t4 c0 granted after clear", got, 1);
    @(posedge px_clk); #1 setClient(0, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge px_clk);
    chk("t4 clear_done count", doneCount, 1);
    nonZero = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] != 3'd0) nonZero++;
    chk("t4 ram nonzero words", nonZero, 0);
    clientAccess(0, 1'b0, 4799, 0, 0, w);
    clientAccess(1, 1'b0, 0, 0, 0, w);

    // Reset in mid-wipe at clr_cnt=100
    doneSnap = doneCount;
    @(posedge px_clk); #1 clear_start = 1'b1;
    for (int i = 1; i <= 101; i++) begin
      @(posedge px_clk); #1;
      clear_start = 1'b0;
      if (i == 100) begin
        @(negedge px_clk);
        chk("t6 sweep addr", int'(ram_addr), 99);
      end
    end
    rstn = 1'b0;
    @(negedge px_clk);
    chk("t6 ram_we in reset", ram_we, 0);
    @(posedge px_clk); #1;
    rstn = 1'b1;
    setClient(0, 1'b1, 1'b1, 100, 5);
    @(negedge px_clk);
    chk("t6 busy after reset", clear_busy, 0);
    chk("t6 c0_gnt after reset", c0If.gnt, 1);
    @(posedge px_clk); #1 setClient(0, 1'b0, 1'b0, 0, 0);
    repeat (6) @(negedge px_clk);
    chk("t6 no clear_done", doneCount, doneSnap);
    clientAccess(1, 1'b0, 100, 0, 5, w);

    repeat (4) @(negedge px_clk);
    chk("pending vid reads", vidQ.size(), 0);
    chk("pending c0 reads", c0Q.size(), 0);
    chk("pending c1 reads", c1Q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
